// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
//
// Purpose: picks which reservation-station entries issue each cycle. Each
// class is arbitrated separately: one ALU entry, one LOAD/STORE pair sharing
// a memory port, and two MULT entries sharing one multi-cycle multiplier.
// Every grant is registered and lasts exactly one cycle, so the grant vector
// also tells the reservation station which entries it may free.
//
// Parameters:
//   MULT_LAT      multiplier occupancy in cycles (1..15)
//
// Configuration macro:
//   ISSUE_SCHED_STORE_PRIORITY_EN  defined   -> STORE beats LOAD whenever both
//                                               are eligible (mem_ptr unused)
//                                  undefined -> LOAD/STORE round-robin
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   synchronous active-high reset, beats every other input
//   entry_busy    in   [4:0] entry occupied (0 ALU, 1 LOAD, 2 STORE, 3-4 MULT)
//   entry_ready   in   [4:0] entry operands ready
//   issue_enable  in   global issue permission (low = downstream stall)
//   mem_ready     in   memory port can take one load/store this cycle
//   flush         in   squash pending grants and multiplier occupancy
//   grant         out  [4:0] registered one-cycle issue grant
//   mult_busy     out  multiplier occupied
//   mult_done     out  one-cycle pulse: multiplier result complete
// ---------------------------------------------------------------------------
module issue_scheduler #(
  parameter int MULT_LAT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] entry_busy,
  input  logic [4:0] entry_ready,
  input  logic       issue_enable,
  input  logic       mem_ready,
  input  logic       flush,
  output logic [4:0] grant,
  output logic       mult_busy,
  output logic       mult_done
);

  localparam logic [3:0] LAT_M1 = 4'(MULT_LAT - 1);

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_BUSY = 1'b1
  } mult_state_e;

  mult_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  grant_q, grant_d;
  logic        done_q, done_d;
  logic        mem_ptr_q, mem_ptr_d;
  logic        mult_ptr_q, mult_ptr_d;

  logic [4:0]  eligible;
  logic        mult_slot_free;

  // An entry granted last cycle is still shown as busy by the RS this cycle,
  // so masking with the live grant keeps it from being granted twice.
  assign eligible = entry_busy & entry_ready & ~grant_q;

  // The multiplier can take a new operation while idle, or in the last busy
  // cycle so that back-to-back multiplies have no bubble.
  assign mult_slot_free = (state_q == MULT_IDLE) || (cnt_q == 4'd0);

  // Next-state: multiplier sequencing, per-class arbitration, flush override.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = 5'b00000;
    done_d     = 1'b0;
    mem_ptr_d  = mem_ptr_q;
    mult_ptr_d = mult_ptr_q;

    // Multiplier progress runs regardless of issue_enable.
    case (state_q)
      MULT_IDLE: begin
        state_d = MULT_IDLE;
      end
      MULT_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = MULT_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = MULT_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (issue_enable) begin
      grant_d[0] = eligible[0];

      if (mem_ready) begin
`ifdef ISSUE_SCHED_STORE_PRIORITY_EN
        if (eligible[2]) begin
          grant_d[2] = 1'b1;
        end else if (eligible[1]) begin
          grant_d[1] = 1'b1;
        end else begin
          grant_d[2:1] = 2'b00;
        end
`else
        // Pointer names the preferred entry; after a grant it moves to the loser.
        if (eligible[1] && (!mem_ptr_q || !eligible[2])) begin
          grant_d[1] = 1'b1;
          mem_ptr_d  = 1'b1;
        end else if (eligible[2]) begin
          grant_d[2] = 1'b1;
          mem_ptr_d  = 1'b0;
        end else begin
          mem_ptr_d  = mem_ptr_q;
        end
`endif
      end else begin
        grant_d[2:1] = 2'b00;
      end

      // A new multiply overrides the IDLE return computed above.
      if (mult_slot_free) begin
        if (eligible[3] && (!mult_ptr_q || !eligible[4])) begin
          grant_d[3] = 1'b1;
          mult_ptr_d = 1'b1;
          state_d    = MULT_BUSY;
          cnt_d      = LAT_M1;
        end else if (eligible[4]) begin
          grant_d[4] = 1'b1;
          mult_ptr_d = 1'b0;
          state_d    = MULT_BUSY;
          cnt_d      = LAT_M1;
        end else begin
          mult_ptr_d = mult_ptr_q;
        end
      end else begin
        grant_d[4:3] = 2'b00;
      end
    end else begin
      grant_d = 5'b00000;
    end

    // Flush discards everything speculative but keeps fairness history.
    if (flush) begin
      grant_d    = 5'b00000;
      state_d    = MULT_IDLE;
      cnt_d      = 4'd0;
      done_d     = 1'b0;
      mem_ptr_d  = mem_ptr_q;
      mult_ptr_d = mult_ptr_q;
    end else begin
      done_d     = done_d;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= MULT_IDLE;
      cnt_q      <= 4'd0;
      grant_q    <= 5'b00000;
      done_q     <= 1'b0;
      mem_ptr_q  <= 1'b0;
      mult_ptr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      mem_ptr_q  <= mem_ptr_d;
      mult_ptr_q <= mult_ptr_d;
    end
  end

  assign grant     = grant_q;
  assign mult_busy = (state_q == MULT_BUSY);
  assign mult_done = done_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: a cycle-level behavioural model that tracks
// the multiplier as "cycles of occupancy left", a compare process that checks
// every cycle, literal expectations pinning the directed scenarios, then a
// long randomized run.
module tb_issue_scheduler;

  localparam int LAT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] entry_busy;
  logic [4:0] entry_ready;
  logic       issue_enable;
  logic       mem_ready;
  logic       flush;
  logic [4:0] grant;
  logic       mult_busy;
  logic       mult_done;

  issue_scheduler #(.MULT_LAT(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .entry_busy  (entry_busy),
    .entry_ready (entry_ready),
    .issue_enable(issue_enable),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .grant       (grant),
    .mult_busy   (mult_busy),
    .mult_done   (mult_done)
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: grant shown this cycle, multiplier busy cycles still to
  // show (including this one), done pulse shown this cycle, pointers.
  logic [4:0] m_grant    = 5'b00000;
  int         m_left     = 0;
  bit         m_done     = 1'b0;
  bit         m_mem_ptr  = 1'b0;
  bit         m_mult_ptr = 1'b0;

  // Model temporaries (owned by the model process only).
  logic [4:0] t_elig, t_ng;
  int         t_left, t_pref, t_oth, t_win;
  bit         t_done, t_mp, t_up;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Behavioural model: advances on each rising edge from the inputs applied.
  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_grant = 5'b00000; m_left = 0; m_done = 1'b0;
      m_mem_ptr = 1'b0; m_mult_ptr = 1'b0;
    end else begin
      t_elig = entry_busy & entry_ready & ~m_grant;
      t_ng   = 5'b00000;
      t_left = m_left;
      t_done = 1'b0;
      t_mp   = m_mem_ptr;
      t_up   = m_mult_ptr;
      if (m_left > 0) begin
        t_left = m_left - 1;
        t_done = (t_left == 0);
      end
      if (issue_enable) begin
        t_ng[0] = t_elig[0];
        if (mem_ready) begin
`ifdef ISSUE_SCHED_STORE_PRIORITY_EN
          t_pref = 2;
`else
          t_pref = m_mem_ptr ? 2 : 1;
`endif
          t_oth = 3 - t_pref;
          t_win = t_elig[t_pref] ? t_pref : (t_elig[t_oth] ? t_oth : -1);
          if (t_win > 0) begin
            t_ng[t_win] = 1'b1;
`ifndef ISSUE_SCHED_STORE_PRIORITY_EN
            t_mp = (t_win == 1);
`endif
          end
        end
        if (m_left <= 1) begin
          t_pref = m_mult_ptr ? 4 : 3;
          t_oth  = 7 - t_pref;
          t_win  = t_elig[t_pref] ? t_pref : (t_elig[t_oth] ? t_oth : -1);
          if (t_win > 0) begin
            t_ng[t_win] = 1'b1;
            t_up   = (t_win == 3);
            t_left = LAT;
          end
        end
      end
      if (flush) begin
        t_ng = 5'b00000; t_left = 0; t_done = 1'b0;
        t_mp = m_mem_ptr; t_up = m_mult_ptr;
      end
      m_grant = t_ng; m_left = t_left; m_done = t_done;
      m_mem_ptr = t_mp; m_mult_ptr = t_up;
    end
  end

  // Compare process: DUT against model on every falling edge.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("model_grant", grant, m_grant);
      check("model_mult_busy", {4'b0000, mult_busy}, {4'b0000, (m_left > 0)});
      check("model_mult_done", {4'b0000, mult_done}, {4'b0000, m_done});
    end
  end

  task automatic cyc(input logic [4:0] b, input logic [4:0] r, input logic ie,
                     input logic mr, input logic fl, input logic rs);
    entry_busy = b; entry_ready = r; issue_enable = ie;
    mem_ready = mr; flush = fl; reset = rs;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic outs(input string name, input logic [4:0] g, input logic b, input logic d);
    check({name, "_grant"}, grant, g);
    check({name, "_busy"}, {4'b0000, mult_busy}, {4'b0000, b});
    check({name, "_done"}, {4'b0000, mult_done}, {4'b0000, d});
  endtask

  initial begin
    cyc(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    outs("reset", 5'b00000, 1'b0, 1'b0);

`ifndef ISSUE_SCHED_STORE_PRIORITY_EN
    // All entries eligible; multiply issued at cycle 1, done at cycle 5.
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c1", 5'b01011, 1'b1, 1'b0);
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c2", 5'b00100, 1'b1, 1'b0);
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c3", 5'b00011, 1'b1, 1'b0);
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c4", 5'b00100, 1'b1, 1'b0);
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c5", 5'b10011, 1'b1, 1'b1);
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("all_c6", 5'b00100, 1'b1, 1'b0);
    // Flush in the second busy cycle of the new multiply.
    cyc(5'b11111, 5'b11111, 1'b1, 1'b1, 1'b1, 1'b0);
    outs("flush", 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
      outs("post_flush", 5'b00000, 1'b0, 1'b0);
    end
    // Memory port stalled: only ALU issues.
    cyc(5'b00011, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b0);
    outs("mem_stall", 5'b00001, 1'b0, 1'b0);
    // LOAD/STORE alternation.
    cyc(5'b00110, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    check("alt_1", grant, 5'b00010);
    cyc(5'b00110, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    check("alt_2", grant, 5'b00100);
    cyc(5'b00110, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    check("alt_3", grant, 5'b00010);
    // Reset mid-busy with issue disabled; entry 3 wins again afterwards.
    cyc(5'b11000, 5'b11000, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("m3_grant", 5'b01000, 1'b1, 1'b0);
    cyc(5'b11000, 5'b11000, 1'b0, 1'b1, 1'b0, 1'b0);
    outs("stall_busy", 5'b00000, 1'b1, 1'b0);
    cyc(5'b11000, 5'b11000, 1'b0, 1'b1, 1'b0, 1'b1);
    outs("mid_reset", 5'b00000, 1'b0, 1'b0);
    cyc(5'b11000, 5'b11000, 1'b1, 1'b1, 1'b0, 1'b0);
    outs("after_reset", 5'b01000, 1'b1, 1'b0);
`else
    // Store priority: STORE first, then LOAD while STORE is masked.
    cyc(5'b00110, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_1", grant, 5'b00100);
    cyc(5'b00110, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_2", grant, 5'b00010);
`endif

    // Randomized traffic checked every cycle by the compare process.
    cyc(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      cyc(5'($urandom), 5'($urandom) | 5'($urandom),
          ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 1));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
